// File: rtl/controller_floatingpoint_mul.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : controller_floatingpoint_mul
// Purpose  : Sequencing FSM for the single-precision FP multiplier datapath.
//            Steps IDLE -> LOAD -> MULT -> NORM -> ROUND -> DONE, drives the
//            datapath register/normalise/rounding controls and reports a
//            start/busy/done handshake with a sticky per-operation overflow.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DONE_PULSE              1: done is a one-cycle pulse
//                           0: done holds in DONE until ack_i
// Build macro
//   FPMUL_CTRL_QUEUE_EN     adds a one-deep pending-start latch so a start
//                           received while busy launches straight after DONE
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   start_i, ack_i          request / done acknowledge (ack only if DONE_PULSE=0)
//   MLB_significand_mult_i  product MSB (1 = normalise shift needed)
//   MLB_exp_inc_i           exponent bit 8 after increment
//   overflow_flag_i         overflow from rounding stage
//   mux_en_reg_o            0 = load A/B, 1 = load exp_sum/product
//   enable_reg_o            operand/intermediate register enable
//   inc_shift_en_o          exponent +1 and significand >>1
//   enable_rounding_o       rounding register enable
//   mux_en_rounding_o       1 = rounding output forced to zero
//   no_start_o              1 = rounding stage idle
//   busy_o, done_o          handshake status
//   result_ovf_o            sticky overflow of the current/last operation
// ============================================================================
module controller_floatingpoint_mul #(
  parameter int DONE_PULSE = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  input  logic ack_i,
  input  logic MLB_significand_mult_i,
  input  logic MLB_exp_inc_i,
  input  logic overflow_flag_i,
  output logic mux_en_reg_o,
  output logic enable_reg_o,
  output logic inc_shift_en_o,
  output logic enable_rounding_o,
  output logic mux_en_rounding_o,
  output logic no_start_o,
  output logic busy_o,
  output logic done_o,
  output logic result_ovf_o
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_LOAD  = 3'd1;
  localparam logic [2:0] c_MULT  = 3'd2;
  localparam logic [2:0] c_NORM  = 3'd3;
  localparam logic [2:0] c_ROUND = 3'd4;
  localparam logic [2:0] c_DONE  = 3'd5;

  logic [2:0] state_q, state_d;
  logic       norm_flag_q, norm_flag_d;
  logic       exp_ovf_q, exp_ovf_d;
  logic       result_ovf_q, result_ovf_d;

  logic w_done_exit;   // DONE may be left on this edge
  logic w_pending;     // a queued request is waiting
  logic w_relaunch;    // leave DONE straight into LOAD

  assign w_done_exit = (DONE_PULSE != 0) ? 1'b1 : ack_i;

`ifdef FPMUL_CTRL_QUEUE_EN
  logic pending_q, pending_d;

  assign w_pending  = pending_q;
  // A start arriving on the DONE exit edge itself is folded straight into
  // the relaunch rather than parked in the latch.
  assign w_relaunch = pending_q | start_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    pending_d = pending_q;
    if ((state_q == c_DONE) && w_done_exit) begin
      pending_d = 1'b0;
    end else if (start_i && (state_q != c_IDLE)) begin
      pending_d = 1'b1;
    end
  end
`else
  assign w_pending  = 1'b0;
  assign w_relaunch = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (start_i || w_pending) state_d = c_LOAD;
      c_LOAD:  state_d = c_MULT;
      c_MULT:  state_d = c_NORM;
      c_NORM:  state_d = c_ROUND;
      c_ROUND: state_d = c_DONE;
      c_DONE:  if (w_done_exit) state_d = w_relaunch ? c_LOAD : c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // Status latches sampled from the datapath
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      norm_flag_q  <= 1'b0;
      exp_ovf_q    <= 1'b0;
      result_ovf_q <= 1'b0;
    end else begin
      norm_flag_q  <= norm_flag_d;
      exp_ovf_q    <= exp_ovf_d;
      result_ovf_q <= result_ovf_d;
    end
  end

  always_comb begin
    norm_flag_d  = norm_flag_q;
    exp_ovf_d    = exp_ovf_q;
    result_ovf_d = result_ovf_q;
    if (state_q == c_MULT) begin
      norm_flag_d = MLB_significand_mult_i;
    end
    if (state_q == c_ROUND) begin
      // The exponent bit is captured on the same edge, so combine the live
      // value rather than the not-yet-updated latch.
      exp_ovf_d    = MLB_exp_inc_i;
      result_ovf_d = MLB_exp_inc_i | overflow_flag_i;
    end
    if (state_q == c_DONE) begin
      result_ovf_d = result_ovf_q | exp_ovf_q | overflow_flag_i;
    end
    // Entering LOAD starts a fresh operation; this overrides the DONE hold.
    if (state_d == c_LOAD) begin
      norm_flag_d  = 1'b0;
      exp_ovf_d    = 1'b0;
      result_ovf_d = 1'b0;
    end
  end

  // Output decode: state register and norm_flag only
  always_comb begin
    mux_en_reg_o      = 1'b0;
    enable_reg_o      = 1'b0;
    inc_shift_en_o    = 1'b0;
    enable_rounding_o = 1'b0;
    mux_en_rounding_o = 1'b1;
    no_start_o        = 1'b1;
    busy_o            = 1'b0;
    done_o            = 1'b0;
    case (state_q)
      c_LOAD: begin
        enable_reg_o = 1'b1;
        busy_o       = 1'b1;
      end
      c_MULT: begin
        mux_en_reg_o = 1'b1;
        enable_reg_o = 1'b1;
        busy_o       = 1'b1;
      end
      c_NORM: begin
        inc_shift_en_o = norm_flag_q;
        busy_o         = 1'b1;
      end
      c_ROUND: begin
        inc_shift_en_o    = norm_flag_q;
        enable_rounding_o = 1'b1;
        mux_en_rounding_o = 1'b0;
        no_start_o        = 1'b0;
        busy_o            = 1'b1;
      end
      c_DONE: begin
        // Keep the rounded result visible while done is high.
        mux_en_rounding_o = 1'b0;
        no_start_o        = 1'b0;
        busy_o            = 1'b1;
        done_o            = 1'b1;
      end
      default: ;
    endcase
  end

  assign result_ovf_o = result_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_controller_floatingpoint_mul.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_controller_floatingpoint_mul
// Purpose  : Self-checking bench for controller_floatingpoint_mul. Two
//            instances: u_pulse (DONE_PULSE=1) and u_hold (DONE_PULSE=0).
//            Expected outputs come from a phase timeline: each cycle is
//            classified by its offset from the launching start edge.
//            Honours FPMUL_CTRL_QUEUE_EN for the back-to-back scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controller_floatingpoint_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_p, start_h, ack_p, ack_h, msm, mei, ovf;
  // Output vector bit order:
  // [8] mux_en_reg [7] enable_reg [6] inc_shift_en [5] enable_rounding
  // [4] mux_en_rounding [3] no_start [2] busy [1] done [0] result_ovf
  wire [8:0] out_p, out_h;

  int checks   = 0;
  int failures = 0;
  logic prev_ovf_p = 1'b0;
  logic prev_ovf_h = 1'b0;

  controller_floatingpoint_mul #(.DONE_PULSE(1)) u_pulse (
    .clk_i(clk), .reset_i(reset), .start_i(start_p), .ack_i(ack_p),
    .MLB_significand_mult_i(msm), .MLB_exp_inc_i(mei), .overflow_flag_i(ovf),
    .mux_en_reg_o(out_p[8]), .enable_reg_o(out_p[7]), .inc_shift_en_o(out_p[6]),
    .enable_rounding_o(out_p[5]), .mux_en_rounding_o(out_p[4]),
    .no_start_o(out_p[3]), .busy_o(out_p[2]), .done_o(out_p[1]),
    .result_ovf_o(out_p[0])
  );

  controller_floatingpoint_mul #(.DONE_PULSE(0)) u_hold (
    .clk_i(clk), .reset_i(reset), .start_i(start_h), .ack_i(ack_h),
    .MLB_significand_mult_i(msm), .MLB_exp_inc_i(mei), .overflow_flag_i(ovf),
    .mux_en_reg_o(out_h[8]), .enable_reg_o(out_h[7]), .inc_shift_en_o(out_h[6]),
    .enable_rounding_o(out_h[5]), .mux_en_rounding_o(out_h[4]),
    .no_start_o(out_h[3]), .busy_o(out_h[2]), .done_o(out_h[1]),
    .result_ovf_o(out_h[0])
  );

  // Phase: 0 idle, 1 LOAD, 2 MULT, 3 NORM, 4 ROUND, 5 DONE
  function automatic logic [8:0] exp_vec(input int ph, input logic nf, input logic rovf);
    case (ph)
      0:       exp_vec = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rovf};
      1:       exp_vec = 9'b0_1_0_0_0_0_1_0_0;
      2:       exp_vec = 9'b1_1_0_0_0_0_1_0_0;
      3:       exp_vec = {1'b0, 1'b0, nf, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      4:       exp_vec = {1'b0, 1'b0, nf, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      5:       exp_vec = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, rovf};
      default: exp_vec = 9'b0;
    endcase
  endfunction

  // Which bits the behaviour pins down in each phase
  function automatic logic [8:0] care(input int ph);
    case (ph)
      0:       care = 9'b1_1_1_1_1_1_1_1_1;
      1:       care = 9'b1_1_1_1_0_0_1_1_0;
      2:       care = 9'b1_1_1_1_0_0_1_1_1;
      3:       care = 9'b0_1_1_1_0_0_1_1_1;
      4:       care = 9'b0_0_1_1_1_1_1_1_1;
      5:       care = 9'b0_0_1_1_0_0_1_1_1;
      default: care = 9'b1_1_1_1_1_1_1_1_1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    // start and reset together: reset wins
    reset = 1'b1; start_p = 1'b1; start_h = 1'b1;
    tick(); tick();
    e = exp_vec(0, 1'b0, 1'b0);
    checks++;
    if (out_p !== e) begin
      failures++;
      $display("FAIL reset_pulse got=%b exp=%b", out_p, e);
    end
    checks++;
    if (out_h !== e) begin
      failures++;
      $display("FAIL reset_hold got=%b exp=%b", out_h, e);
    end
    reset = 1'b0; start_p = 1'b0; start_h = 1'b0;
    tick();
    checks++;
    if (out_p !== e) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", out_p, e);
    end
    prev_ovf_p = 1'b0;
    prev_ovf_h = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [8:0] e;
    msm = 1'b1; mei = 1'b1; ovf = 1'b1;
    start_p = 1'b1; tick(); start_p = 1'b0;
    tick(); tick();
    e = exp_vec(3, 1'b1, 1'b0);
    checks++;
    if (((out_p ^ e) & care(3)) !== 9'b0) begin
      failures++;
      $display("FAIL midop_norm got=%b exp=%b care=%b", out_p, e, care(3));
    end
    reset = 1'b1; tick(); reset = 1'b0;
    prev_ovf_p = 1'b0;
    e = exp_vec(0, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (out_p !== e) begin
        failures++;
        $display("FAIL midop_abandon cyc=%0d got=%b exp=%b", c, out_p, e);
      end
      tick();
    end
  endtask

  // First three operations follow directed cases, then random ones
  task automatic test_ops(input int n);
    logic nf, ei, of, rovf;
    logic [8:0] e;
    for (int i = 0; i < n; i++) begin
      case (i)
        0:       {nf, ei, of} = 3'b000;  // 2.0 x 3.0
        1:       {nf, ei, of} = 3'b100;  // 1.5 x 1.5
        2:       {nf, ei, of} = 3'b010;  // 0x7F000000 squared
        default: {nf, ei, of} = 3'($urandom_range(0, 7));
      endcase
      msm = nf; mei = ei; ovf = of;
      repeat ($urandom_range(0, 3)) begin
        tick();
        e = exp_vec(0, 1'b0, prev_ovf_p);
        checks++;
        if (out_p !== e) begin
          failures++;
          $display("FAIL ops_gap op=%0d got=%b exp=%b", i, out_p, e);
        end
      end
      start_p = 1'b1; tick(); start_p = 1'b0;
      for (int ph = 1; ph <= 5; ph++) begin
        rovf = (ph == 5) ? (ei | of) : 1'b0;
        e = exp_vec(ph, nf, rovf);
        checks++;
        if (((out_p ^ e) & care(ph)) !== 9'b0) begin
          failures++;
          $display("FAIL ops_phase op=%0d ph=%0d got=%b exp=%b care=%b", i, ph, out_p, e, care(ph));
        end
`ifndef FPMUL_CTRL_QUEUE_EN
        if ($urandom_range(0, 3) == 0) start_p = 1'b1;  // must be ignored
`endif
        tick(); start_p = 1'b0;
      end
      prev_ovf_p = ei | of;
      e = exp_vec(0, 1'b0, prev_ovf_p);
      checks++;
      if (out_p !== e) begin
        failures++;
        $display("FAIL ops_after op=%0d got=%b exp=%b", i, out_p, e);
      end
    end
  endtask

  task automatic test_hold();
    logic [8:0] e;
    logic of2;
    msm = 1'b0; mei = 1'b0; ovf = 1'b1;
    ack_h = 1'b0;
    start_h = 1'b1; tick(); start_h = 1'b0;
    for (int ph = 1; ph <= 4; ph++) begin
      e = exp_vec(ph, 1'b0, 1'b0);
      checks++;
      if (((out_h ^ e) & care(ph)) !== 9'b0) begin
        failures++;
        $display("FAIL hold_phase ph=%0d got=%b exp=%b", ph, out_h, e);
      end
      tick();
    end
    e = exp_vec(5, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) ack_h = 1'b1;
      checks++;
      if (((out_h ^ e) & care(5)) !== 9'b0) begin
        failures++;
        $display("FAIL hold_done cyc=%0d got=%b exp=%b", c, out_h, e);
      end
      tick();
    end
    ack_h = 1'b0;
    prev_ovf_h = 1'b1;
    e = exp_vec(0, 1'b0, 1'b1);
    checks++;
    if (out_h !== e) begin
      failures++;
      $display("FAIL hold_exit got=%b exp=%b", out_h, e);
    end
    // ack in idle is ignored; ack present in first DONE cycle exits at once
    of2 = 1'($urandom_range(0, 1));
    ovf = of2; msm = 1'b1;
    ack_h = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (out_h !== e) begin
        failures++;
        $display("FAIL hold_idle_ack cyc=%0d got=%b exp=%b", c, out_h, e);
      end
    end
    start_h = 1'b1; tick(); start_h = 1'b0;
    for (int ph = 1; ph <= 5; ph++) begin
      e = exp_vec(ph, 1'b1, (ph == 5) ? of2 : 1'b0);
      checks++;
      if (((out_h ^ e) & care(ph)) !== 9'b0) begin
        failures++;
        $display("FAIL hold_fast ph=%0d got=%b exp=%b", ph, out_h, e);
      end
      tick();
    end
    ack_h = 1'b0;
    prev_ovf_h = of2;
    e = exp_vec(0, 1'b0, of2);
    checks++;
    if (out_h !== e) begin
      failures++;
      $display("FAIL hold_fast_exit got=%b exp=%b", out_h, e);
    end
  endtask

  // start at edge k, k+2 and k+3
  task automatic test_back_to_back();
    logic nf, ei, of;
    logic [8:0] e;
    int ph;
    {nf, ei, of} = 3'($urandom_range(0, 7));
    msm = nf; mei = ei; ovf = of;
    start_p = 1'b1; tick(); start_p = 1'b0;
    for (int c = 1; c <= 12; c++) begin
`ifdef FPMUL_CTRL_QUEUE_EN
      ph = (c <= 5) ? c : (c <= 10) ? c - 5 : 0;
`else
      ph = (c <= 5) ? c : 0;
`endif
      e = exp_vec(ph, nf, ((ph == 5) || (ph == 0)) ? (ei | of) : 1'b0);
      checks++;
      if (((out_p ^ e) & care(ph)) !== 9'b0) begin
        failures++;
        $display("FAIL b2b cyc=%0d ph=%0d got=%b exp=%b care=%b", c, ph, out_p, e, care(ph));
      end
      start_p = (c == 2) || (c == 3);
      tick(); start_p = 1'b0;
    end
    prev_ovf_p = ei | of;
  endtask

  initial begin
    reset = 1'b1; start_p = 1'b0; start_h = 1'b0;
    ack_p = 1'b0; ack_h = 1'b0; msm = 1'b0; mei = 1'b0; ovf = 1'b0;
    test_reset();
    test_reset_midop();
    test_ops(40);
    test_hold();
    test_back_to_back();
    test_ops(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/controller_floatingpoint_mul.md
# controller_floatingpoint_mul

Sequencing FSM for the single-precision floating-point multiplier datapath. It drives the datapath's register-select, register-enable, normalise, rounding-enable and zero-output controls, and samples its normalise/overflow status bits. It presents a start/busy/done handshake to the requester. It sits beside the datapath inside the FP multiplier IP top level.

## Interface
Parameters:
- DONE_PULSE, default 1: 1 = `done` is a one-cycle pulse; 0 = `done` holds in DONE until `ack`.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; operands A/B must be stable at the datapath input during the LOAD cycle
- ack  in  1  done acknowledge (used only when DONE_PULSE=0)
- MLB_significand_mult  in  1  product MSB from datapath; 1 = shift needed
- MLB_exp_inc  in  1  exponent bit 8 after increment
- overflow_flag  in  1  overflow from the rounding stage
- mux_en_reg  out  1  0 = load A/B, 1 = load exp_sum/product
- enable_reg  out  1  operand/intermediate register enable
- inc_shift_en  out  1  exponent +1 and significand >>1
- enable_rounding  out  1  rounding register enable
- mux_en_rounding  out  1  1 = rounding output forced to zero
- no_start  out  1  1 = rounding stage idle
- busy  out  1  operation in flight
- done  out  1  result valid
- result_ovf  out  1  sticky per-operation overflow (exponent or rounding)

## Operation
- States: IDLE, LOAD, MULT, NORM, ROUND, DONE (3-bit encoding).
- IDLE: no_start=1, mux_en_rounding=1, all other controls 0. Transition: start=1 → LOAD.
- LOAD: enable_reg=1, mux_en_reg=0. Transition: → MULT unconditionally.
- MULT: enable_reg=1, mux_en_reg=1. Latch norm_flag ← MLB_significand_mult.
- NORM: inc_shift_en=norm_flag, enable_reg=0.
- ROUND:
  - enable_rounding=1, mux_en_rounding=0, no_start=0, inc_shift_en=norm_flag.
  - Latch exp_ovf ← MLB_exp_inc.
- DONE:
  - done=1, busy=1.
  - result_ovf = exp_ovf | overflow_flag, registered on entry and held until the next LOAD.
- Leaving DONE:
  - DONE_PULSE=1: after 1 cycle → IDLE.
  - DONE_PULSE=0: stay until ack=1, then → IDLE.
- In IDLE, ack is ignored.
- Controls are decoded from the state register and norm_flag only; no combinational path from start to any output.
- busy=1 in LOAD..DONE.
- norm_flag and exp_ovf clear on LOAD.

## Timing
- start sampled high at edge k (in IDLE):
  - LOAD in cycle k+1, MULT in k+2, NORM in k+3, ROUND in k+4.
  - done=1 in cycle k+5 (DONE_PULSE=1).
  - Latency is 5 cycles; result is valid on the datapath `result` while done=1.
- Minimum back-to-back interval (no queue): 6 cycles (DONE → IDLE → LOAD).
- start while busy is ignored, unless the configuration feature is enabled.
- Reset at any edge:
  - State → IDLE, norm_flag/exp_ovf/result_ovf/pending → 0.
  - Outputs: no_start=1, mux_en_rounding=1, all others 0.
  - Any in-flight operation is abandoned; no done.
- start and reset in the same cycle: reset wins.
- DONE_PULSE=0 with ack in the first DONE cycle: exit after that cycle (same as a pulse).

## Configuration
- FPMUL_CTRL_QUEUE_EN defined:
  - One-deep pending latch: start=1 while busy sets pending (a second start while pending is dropped).
  - On leaving DONE with pending=1, go directly to LOAD (skip IDLE) and clear pending.
  - Back-to-back interval becomes 5 cycles.
  - The requester must present the new operands by the LOAD cycle.
- Not defined: no pending logic; start while busy is ignored.

## Test plan
- 0x40000000 × 0x40400000 (2.0×3.0):
  - norm_flag=0, inc_shift_en never 1.
  - done at k+5, result 0x40C00000, result_ovf=0.
- 0x3FC00000 × 0x3FC00000 (1.5×1.5):
  - inc_shift_en=1 in NORM and ROUND.
  - Result 0x40100000, done at k+5.
- 0x7F000000 × 0x7F000000: result_ovf=1 in DONE; it clears on the next LOAD.
- reset asserted in NORM:
  - Next cycle IDLE, no_start=1, mux_en_rounding=1, busy=0.
  - No done pulse; a fresh start completes normally.
- DONE_PULSE=0: done held high for 4 cycles with ack=0; ack=1 → IDLE next cycle, done=0.
- FPMUL_CTRL_QUEUE_EN: start at k and k+2:
  - Second operation's LOAD at k+6, done at k+5 and k+10.
  - A third start at k+3 is dropped.
